// File: rtl/dma_rx_pkt_reader.sv
// dma_rx_pkt_reader
// Memory-to-CGRA read engine of the duplex DMA ("rx" direction).
// Fetches a run of 24-byte packet containers from SRAM, three 64-bit beats per
// container, and hands the low PKT_W bits of each container to the CGRA over a
// val/rdy stream. Busy, sticky done and a packet counter go back to the
// MMIO status block.
module dma_rx_pkt_reader #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int PKT_W  = 185,
    parameter int LEN_W  = 16,
    parameter int BEATS  = 3
) (
    input  logic              clk,
    input  logic              reset,

    // configuration / status
    input  logic [ADDR_W-1:0] cfg_src,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              cfg_start,
    output logic              stat_busy,
    output logic              stat_done,
    output logic [LEN_W-1:0]  stat_pkt_cnt,

    // SRAM read port
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,

    // CGRA packet stream
    output logic              send_pkt__val,
    input  logic              send_pkt__rdy,
    output logic [PKT_W-1:0]  send_pkt__msg
);

    localparam int BUF_W    = BEATS * DATA_W;
    localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BEAT_B   = DATA_W / 8;
    localparam int ALIGN    = $clog2(BEAT_B);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_SEND
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_pkt_cnt;
    logic [BEAT_W-1:0]   r_beat;
    logic [BUF_W-1:0]    r_buf;
    logic                r_req;
    logic                r_val;
    logic [PKT_W-1:0]    r_msg;
    logic                r_busy;
    logic                r_done;

    logic [ADDR_W-1:0]   w_base;
    logic [ADDR_W-1:0]   w_addr_inc;
    logic [LEN_W-1:0]    w_cnt_inc;
    logic                w_beat_last;
    logic [BUF_W-1:0]    w_asm;
    logic                w_unused;

    // Containers are contiguous, so base + pkt_idx*24 + beat*8 is the same as a
    // running byte address that advances one beat (8 bytes) per returned beat.
    assign w_base      = {cfg_src[ADDR_W-1:ALIGN], {ALIGN{1'b0}}};
    assign w_addr_inc  = r_addr + ADDR_W'(BEAT_B);
    assign w_cnt_inc   = r_pkt_cnt + LEN_W'(1);
    assign w_beat_last = (r_beat == BEAT_W'(BEATS - 1));

    // Container pad bits above the packet and the sub-beat source offset are
    // deliberately dropped.
    assign w_unused = ^{w_asm[BUF_W-1:PKT_W], cfg_src[ALIGN-1:0]};

    // Assembly buffer with the incoming beat merged into its slot, so the last
    // beat can go straight into the outgoing message register.
    always_comb begin
        w_asm = r_buf;
        for (int b = 0; b < BEATS; b++) begin
            if (r_beat == BEAT_W'(b)) begin
                w_asm[b*DATA_W +: DATA_W] = mem_rdata;
            end
        end
    end

    // Transfer FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_len     <= '0;
            r_pkt_cnt <= '0;
            r_beat    <= '0;
            r_buf     <= '0;
            r_req     <= 1'b0;
            r_val     <= 1'b0;
            r_msg     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_start) begin
                        r_len     <= cfg_len;
                        r_addr    <= w_base;
                        r_pkt_cnt <= '0;
                        r_beat    <= '0;
                        if (cfg_len == '0) begin
                            // empty run completes immediately without touching SRAM
                            r_done <= 1'b1;
                        end else begin
                            r_done  <= 1'b0;
                            r_busy  <= 1'b1;
                            r_req   <= 1'b1;
                            r_state <= S_REQ;
                        end
                    end
                end

                S_REQ: begin
                    // request and address stay put until granted
                    if (mem_gnt) begin
                        r_req   <= 1'b0;
                        r_state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (mem_rvalid) begin
                        r_buf  <= w_asm;
                        r_addr <= w_addr_inc;
                        if (w_beat_last) begin
                            r_beat  <= '0;
                            r_val   <= 1'b1;
                            r_msg   <= w_asm[PKT_W-1:0];
                            r_state <= S_SEND;
                        end else begin
                            r_beat  <= r_beat + BEAT_W'(1);
                            r_req   <= 1'b1;
                            r_state <= S_REQ;
                        end
                    end
                end

                S_SEND: begin
                    // message is held until the CGRA takes it
                    if (send_pkt__rdy) begin
                        r_val     <= 1'b0;
                        r_pkt_cnt <= w_cnt_inc;
                        if (w_cnt_inc == r_len) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_req   <= 1'b1;
                            r_state <= S_REQ;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign stat_busy     = r_busy;
    assign stat_done     = r_done;
    assign stat_pkt_cnt  = r_pkt_cnt;
    assign mem_req       = r_req;
    assign mem_addr      = r_addr;
    assign send_pkt__val = r_val;
    assign send_pkt__msg = r_msg;

endmodule

// File: tb/tb_dma_rx_pkt_reader.sv
// tb_dma_rx_pkt_reader
// Directed bench for the rx packet reader: SRAM responder, transfer-level
// reference model with per-cycle compare, plus hand-computed expectations.
module tb_dma_rx_pkt_reader;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int PKT_W  = 185;
    localparam int LEN_W  = 16;

    // packet 0 of the preloaded run: {word2[56:0], word1, word0}
    localparam logic [PKT_W-1:0] PKT0 =
        {57'h1C0_0000_0000_3300, 64'h1111_0000_0000_0000, 64'h0000_0000_DEAD_0000};

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] cfg_src = '0;
    logic [LEN_W-1:0]  cfg_len = '0;
    logic              cfg_start = 1'b0;
    logic              stat_busy;
    logic              stat_done;
    logic [LEN_W-1:0]  stat_pkt_cnt;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt = 1'b0;
    logic              mem_rvalid = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              send_pkt__val;
    logic              send_pkt__rdy = 1'b1;
    logic [PKT_W-1:0]  send_pkt__msg;

    dma_rx_pkt_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PKT_W(PKT_W), .LEN_W(LEN_W), .BEATS(3)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_src(cfg_src), .cfg_len(cfg_len), .cfg_start(cfg_start),
        .stat_busy(stat_busy), .stat_done(stat_done), .stat_pkt_cnt(stat_pkt_cnt),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .send_pkt__val(send_pkt__val), .send_pkt__rdy(send_pkt__rdy),
        .send_pkt__msg(send_pkt__msg)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // SRAM contents
    logic [63:0] mem [logic [63:0]];

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return 64'h0;
    endfunction

    // reference model and observation state
    bit               m_busy = 0;
    bit               m_done = 0;
    int               m_cnt = 0;
    int               m_len = 0;
    logic [63:0]      exp_addr[$];
    logic [PKT_W-1:0] exp_msg[$];
    logic [63:0]      obs_addr[$];
    logic [PKT_W-1:0] obs_msg[$];
    int               hs_cyc[$];
    int               start_cyc = 0;
    int               cyc = 0;
    int               n_grants = 0;
    int               n_hs = 0;
    int               n_stall = 0;
    int               n_reqwait = 0;
    bit               prev_req_wait = 0;
    bit               prev_val_wait = 0;
    logic [63:0]      prev_addr = '0;
    logic [PKT_W-1:0] prev_msg = '0;

    // SRAM responder state
    bit               pending = 0;
    logic [63:0]      paddr = '0;
    logic [63:0]      blk_addr = '0;
    int               blk_cnt = 0;
    bit               spurious = 0;

    // Compare against the model, then fold in the events of the coming edge.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            m_busy = 0; m_done = 0; m_cnt = 0; m_len = 0;
            exp_addr.delete(); exp_msg.delete();
            pending = 0; prev_req_wait = 0; prev_val_wait = 0;
            chk("reset_ctrl", 192'({mem_req, send_pkt__val, stat_busy, stat_done}), 192'(4'b0));
        end else begin
            chk("busy", 192'(stat_busy), 192'(m_busy));
            chk("done", 192'(stat_done), 192'(m_done));
            chk("pkt_cnt", 192'(stat_pkt_cnt), 192'(m_cnt));
            chk("req_during_send", 192'(mem_req & send_pkt__val), 192'(0));
            if (prev_req_wait)
                chk("req_hold", 192'({mem_req, mem_addr}), 192'({1'b1, prev_addr}));
            if (prev_val_wait)
                chk("msg_hold", 192'({send_pkt__val, send_pkt__msg}), 192'({1'b1, prev_msg}));

            if (cfg_start && !m_busy) begin
                logic [63:0] base;
                base = cfg_src & ~64'h7;
                m_len = int'(cfg_len);
                m_cnt = 0;
                start_cyc = cyc;
                m_busy = (m_len != 0);
                m_done = (m_len == 0);
                for (int p = 0; p < m_len; p++) begin
                    logic [191:0] c;
                    for (int b = 0; b < 3; b++) begin
                        logic [63:0] a;
                        a = base + 64'(24 * p + 8 * b);
                        exp_addr.push_back(a);
                        c[b*64 +: 64] = mem_rd(a);
                    end
                    exp_msg.push_back(c[PKT_W-1:0]);
                end
            end

            if (mem_req && mem_gnt) begin
                chk("req_expected", 192'(exp_addr.size() != 0), 192'(1));
                if (exp_addr.size() != 0)
                    chk("req_addr", 192'(mem_addr), 192'(exp_addr.pop_front()));
                n_grants++;
                pending = 1;
                paddr = mem_addr;
                obs_addr.push_back(mem_addr);
            end
            if (mem_req && !mem_gnt) n_reqwait++;

            if (send_pkt__val && send_pkt__rdy) begin
                chk("msg_expected", 192'(exp_msg.size() != 0), 192'(1));
                if (exp_msg.size() != 0)
                    chk("msg", 192'(send_pkt__msg), 192'(exp_msg.pop_front()));
                obs_msg.push_back(send_pkt__msg);
                hs_cyc.push_back(cyc);
                n_hs++;
                m_cnt++;
                if (m_cnt == m_len) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
            if (send_pkt__val && !send_pkt__rdy) n_stall++;

            prev_req_wait = mem_req && !mem_gnt;
            prev_addr     = mem_addr;
            prev_val_wait = send_pkt__val && !send_pkt__rdy;
            prev_msg      = send_pkt__msg;
        end
    end

    // SRAM responder: grant (optionally withheld), read data one cycle later.
    always @(posedge clk) begin
        #2;
        if (mem_req && blk_cnt > 0 && mem_addr == blk_addr) begin
            mem_gnt = 1'b0;
            blk_cnt--;
        end else begin
            mem_gnt = mem_req;
        end
        if (pending) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_rd(paddr);
            pending    = 0;
        end else begin
            mem_rvalid = spurious;
            mem_rdata  = {$urandom, $urandom};
        end
    end

    task automatic clear_obs();
        obs_addr.delete(); obs_msg.delete(); hs_cyc.delete();
        n_grants = 0; n_hs = 0; n_stall = 0; n_reqwait = 0;
    endtask

    task automatic start(input logic [63:0] src, input logic [15:0] len);
        @(posedge clk); #1;
        cfg_src = src; cfg_len = len; cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk); #1;
            if (!m_busy && exp_addr.size() == 0 && exp_msg.size() == 0) begin
                ok = 1;
                break;
            end
        end
        @(negedge clk); #1;
        chk({name, "_completed"}, 192'(ok), 192'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        for (int i = 0; i < 3; i++) begin
            mem[64'h1000 + 64'(24 * i)]      = 64'h0000_0000_DEAD_0000 + 64'(i);
            mem[64'h1000 + 64'(24 * i + 8)]  = 64'h1111_0000_0000_0000 | 64'(i);
            mem[64'h1000 + 64'(24 * i + 16)] = 64'hFFC0_0000_0000_3300 | 64'(i);
        end

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req",  192'(mem_req), 192'(0));
        chk("rst_mem_addr", 192'(mem_addr), 192'(0));
        chk("rst_val",      192'(send_pkt__val), 192'(0));
        chk("rst_msg",      192'(send_pkt__msg), 192'(0));
        chk("rst_status",   192'({stat_busy, stat_done, stat_pkt_cnt}), 192'(0));
        reset = 1'b0;

        // basic 3-packet run
        clear_obs();
        start(64'h1000, 16'd3);
        @(negedge clk);
        chk("t1_first_req", 192'({mem_req, mem_addr}), 192'({1'b1, 64'h1000}));
        wait_idle("t1");
        chk("t1_nreq",   192'(obs_addr.size()), 192'(9));
        chk("t1_addr0",  192'(obs_addr[0]), 192'(64'h1000));
        chk("t1_addr1",  192'(obs_addr[1]), 192'(64'h1008));
        chk("t1_addr8",  192'(obs_addr[8]), 192'(64'h1040));
        chk("t1_msg0",   192'(obs_msg[0]), 192'(PKT0));
        chk("t1_lat0",   192'(hs_cyc[0] - start_cyc), 192'(7));
        chk("t1_lat1",   192'(hs_cyc[1] - hs_cyc[0]), 192'(7));
        chk("t1_lat2",   192'(hs_cyc[2] - hs_cyc[1]), 192'(7));
        chk("t1_final",  192'({stat_busy, stat_done, stat_pkt_cnt}), 192'({1'b0, 1'b1, 16'd3}));

        // back-pressure on packet 1, with stray rvalid pulses while sending
        clear_obs();
        start(64'h1000, 16'd3);
        ok = 0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk); #1;
            ok = (n_hs == 1);
        end
        @(posedge clk); #1;
        send_pkt__rdy = 1'b0;
        ok = 0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk); #1;
            ok = send_pkt__val;
        end
        chk("t2_val_seen", 192'(ok), 192'(1));
        @(posedge clk); #1;
        spurious = 1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("t2_val_stalled", 192'(send_pkt__val), 192'(1));
        @(posedge clk); #1;
        spurious = 0;
        send_pkt__rdy = 1'b1;
        wait_idle("t2");
        chk("t2_stall_cycles", 192'(n_stall), 192'(10));
        chk("t2_npkts", 192'(obs_msg.size()), 192'(3));
        chk("t2_final", 192'({stat_busy, stat_done, stat_pkt_cnt}), 192'({1'b0, 1'b1, 16'd3}));

        // zero-length run
        clear_obs();
        start(64'h3000, 16'd0);
        @(negedge clk);
        chk("t3_done", 192'({stat_busy, stat_done, mem_req}), 192'({1'b0, 1'b1, 1'b0}));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_no_req", 192'({mem_req, stat_busy}), 192'(0));
        end

        // grant withheld five cycles on beat 1
        clear_obs();
        blk_addr = 64'h1008;
        blk_cnt  = 5;
        start(64'h1000, 16'd3);
        wait_idle("t4");
        chk("t4_req_waits", 192'(n_reqwait), 192'(5));
        chk("t4_msg0", 192'(obs_msg[0]), 192'(PKT0));
        chk("t4_cnt", 192'(stat_pkt_cnt), 192'(3));

        // start while busy is ignored; unaligned source is aligned down
        clear_obs();
        start(64'h1000, 16'd3);
        repeat (4) @(posedge clk);
        start(64'h2000, 16'd1);
        wait_idle("t5a");
        chk("t5_nreq", 192'(obs_addr.size()), 192'(9));
        chk("t5_addr8", 192'(obs_addr[8]), 192'(64'h1040));
        chk("t5_cnt", 192'(stat_pkt_cnt), 192'(3));
        clear_obs();
        start(64'h1003, 16'd1);
        @(negedge clk);
        chk("t5_aligned", 192'({mem_req, mem_addr}), 192'({1'b1, 64'h1000}));
        wait_idle("t5b");
        chk("t5b_msg0", 192'(obs_msg[0]), 192'(PKT0));
        chk("t5b_final", 192'({stat_done, stat_pkt_cnt}), 192'({1'b1, 16'd1}));

        // asynchronous reset while waiting for packet 1 beat 2
        clear_obs();
        start(64'h1000, 16'd3);
        ok = 0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk); #1;
            ok = (n_grants == 6);
        end
        chk("t6_reached", 192'(ok), 192'(1));
        chk("t6_addr5", 192'(obs_addr[5]), 192'(64'h1028));
        @(posedge clk); #3;
        reset = 1'b1;
        mem_rvalid = 1'b0;
        pending = 0;
        #1;
        chk("t6_async_ctrl", 192'({mem_req, send_pkt__val, stat_busy, stat_done}), 192'(0));
        chk("t6_async_addr", 192'(mem_addr), 192'(0));
        chk("t6_async_msg", 192'(send_pkt__msg), 192'(0));
        chk("t6_async_cnt", 192'(stat_pkt_cnt), 192'(0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_obs();
        start(64'h1000, 16'd3);
        wait_idle("t6");
        chk("t6_nreq", 192'(obs_addr.size()), 192'(9));
        chk("t6_msg0", 192'(obs_msg[0]), 192'(PKT0));
        chk("t6_final", 192'({stat_busy, stat_done, stat_pkt_cnt}), 192'({1'b0, 1'b1, 16'd3}));

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dma_rx_pkt_reader.md
Name: dma_rx_pkt_reader

Overview:
- Memory-to-CGRA read engine of the duplex DMA (the "rx" direction driven by reg_src_rx / reg_len_rx / reg_start_rx).
- Fetches a run of 24-byte packet containers from the on-chip SRAM through a 64-bit read port.
- Reassembles each container from three beats and presents the low 185 bits as one IntraCgraPacket on a val/rdy stream into the multi-CGRA recv_from_cpu_pkt port.
- Reports busy, done and progress back to the MMIO status block.

Parameters:
ADDR_W, 64, byte-address width of SRAM read port and cfg_src
DATA_W, 64, SRAM read data width (one beat)
PKT_W, 185, CGRA packet width driven on send_pkt__msg
LEN_W, 16, width of packet count / progress counter
BEATS, 3, beats per packet container (BEATS*DATA_W = 192 >= PKT_W)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
cfg_src  input  ADDR_W  byte address of first container; latched on start
cfg_len  input  LEN_W  number of packets; latched on start
cfg_start  input  1  one-cycle start strobe
stat_busy  output  1  transfer in progress
stat_done  output  1  sticky completion flag
stat_pkt_cnt  output  LEN_W  packets handed to CGRA in current/last run
mem_req  output  1  read request valid
mem_addr  output  ADDR_W  read byte address, 8-byte aligned
mem_gnt  input  1  request accepted this cycle
mem_rvalid  input  1  read data valid
mem_rdata  input  DATA_W  read data
send_pkt__val  output  1  packet valid to CGRA
send_pkt__rdy  input  1  CGRA ready
send_pkt__msg  output  PKT_W  packet to CGRA

Behaviour:
- Reset (async, any state): FSM -> IDLE. mem_req, send_pkt__val, stat_busy and stat_done = 0. stat_pkt_cnt, beat index and assembly buffer cleared. mem_addr = 0, send_pkt__msg = 0.
- States: IDLE, REQ, WAIT, SEND.
- IDLE:
  - On cfg_start: latch base = {cfg_src[ADDR_W-1:3], 3'b0} and len; clear stat_done and stat_pkt_cnt; beat = 0.
  - len == 0: set stat_done next cycle, stay IDLE, no mem_req.
  - Otherwise -> REQ; stat_busy = 1 from the next cycle.
- REQ:
  - mem_req = 1, mem_addr = base + pkt_idx*24 + beat*8 (modulo 2^ADDR_W).
  - Both held stable until mem_gnt. On mem_gnt -> WAIT.
  - Exactly one outstanding request at any time.
- WAIT:
  - mem_rvalid arrives no earlier than the cycle after mem_gnt.
  - On mem_rvalid: buf[beat*64 +: 64] <= mem_rdata.
  - beat < 2: beat++, -> REQ. beat == 2: beat = 0, -> SEND.
  - mem_rvalid in any state other than WAIT is ignored.
- SEND:
  - send_pkt__val = 1, send_pkt__msg = buf[184:0]; buf[191:185] discarded.
  - msg held stable while val && !rdy; val never deasserts before handshake.
  - On rdy: stat_pkt_cnt++.
    - If the new count == len: -> IDLE, stat_busy = 0, stat_done = 1 (same edge).
    - Else pkt_idx++, -> REQ.
- Latency: first mem_req the cycle after cfg_start. With zero-wait gnt, 1-cycle rvalid and rdy held high, a packet takes 7 cycles (3x REQ+WAIT, 1 SEND).
- cfg_start while stat_busy: ignored; latched config unchanged.
- cfg_start while stat_done = 1 and idle: starts a new run and clears done.
- stat_done stays high until the next accepted cfg_start or reset.
- Reset mid-packet: partially assembled packet discarded, no val emitted after reset; SRAM-side request dropped.

Test Plan:
- 3 containers preloaded at 0x1000 (payload low bits DEAD_0000+i); cfg_src=0x1000, cfg_len=3; gnt immediate, rvalid +1, rdy=1 -> mem_addr sequence 0x1000,0x1008,0x1010,…,0x1040. Three msgs equal container[184:0]. stat_done=1 and stat_pkt_cnt=3 on the third handshake; first req 1 cycle after start.
- Same run with send_pkt__rdy low for 10 cycles at packet 1 -> val and msg stable throughout, no mem_req while in SEND, final count 3.
- cfg_len=0 -> stat_done=1 one cycle after start, mem_req never asserted, stat_busy stays 0.
- mem_gnt withheld 5 cycles on beat 1 -> mem_req=1 and mem_addr=0x1008 stable for all 5 cycles. Assembled packet still correct.
- cfg_start (src=0x2000) pulsed mid-run -> ignored, addresses continue from 0x1000 base. cfg_src=0x1003 -> first mem_addr 0x1000.
- reset asserted in WAIT of packet 1 beat 2 -> all outputs 0 immediately (async). After release, a new start at 0x1000 replays from packet 0 with correct data.
